// File: rtl/npc_pkg.sv
// Shared constants and types for the fetch front end.
package npc_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ifu_if.sv
// Bundle of the fetch unit's memory, decode and redirect signals.
// master = fetch unit side, slave = memory/decode/execute side.
interface ifu_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch in flight, single-entry output buffer,
// redirects squash the in-flight word through a drop flag.
module ifu #(
    parameter logic [31:0] RESET_PC = npc_pkg::RESET_PC
) (
    input  logic clk,
    input  logic rst_n,
    ifu_if.master bus
);
    import npc_pkg::*;

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic [31:0] redirect_target;

    assign redirect        = bus.redirect_valid && (state_q != IDLE);
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        misalign_d  = redirect && (bus.redirect_pc[1:0] != 2'b00);

        if (redirect) begin
            pc_d = redirect_target;
        end

        case (state_q)
            IDLE: begin
                state_d     = REQ;
                req_valid_d = 1'b1;
                req_addr_d  = pc_q;
            end
            REQ: begin
                // An unaccepted request keeps its address; only its answer is squashed.
                if (redirect) begin
                    drop_d = 1'b1;
                end
                if (bus.imem_req_ready) begin
                    state_d     = WAIT;
                    req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (redirect || drop_q) begin
                        drop_d      = 1'b0;
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = pc_d;
                    end else begin
                        out_instr_d = bus.imem_rsp_data;
                        out_pc_d    = pc_q;
                        pc_d        = pc_q + 32'd4;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect || bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_addr_d  = pc_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= RESET_PC;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = req_addr_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_instr      = out_instr_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.misalign_err   = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the fetch stream.
module tb_ifu;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_if bus();

    ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},  bus.imem_req_addr,       32'h8000_0000);
        chk({tag, "_out_valid"}, 32'(bus.out_valid),      32'd0);
        chk({tag, "_out_instr"}, bus.out_instr,           32'h0000_0013);
        chk({tag, "_out_pc"},    bus.out_pc,              32'h8000_0000);
        chk({tag, "_misalign"},  32'(bus.misalign_err),   32'd0);
    endtask

    // Entered at a negedge with the unit in REQ; leaves it back in REQ.
    task automatic fetch(input logic [31:0] addr, input int hold);
        logic [31:0] word;
        word = mem_word(addr);
        chk("fetch_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("fetch_req_addr",  bus.imem_req_addr,       addr);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk("fetch_req_drop",  32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = word;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        chk("fetch_out_valid", 32'(bus.out_valid), 32'd1);
        chk("fetch_out_instr", bus.out_instr,      word);
        chk("fetch_out_pc",    bus.out_pc,         addr);
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            cyc();
            chk("hold_out_valid", 32'(bus.out_valid),      32'd1);
            chk("hold_out_instr", bus.out_instr,           word);
            chk("hold_out_pc",    bus.out_pc,              addr);
            chk("hold_no_req",    32'(bus.imem_req_valid), 32'd0);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("fetch_consumed", 32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] arch_pc;
    logic [31:0] pend_addr;
    logic [31:0] prev_addr;
    logic        pending;
    logic        prev_stall;
    logic        exp_mis;
    int          cnt;
    int          delivered;
    int          t0;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset values and three zero-wait fetches
        repeat (2) cyc();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cyc();
        t0 = cycle;
        fetch(32'h8000_0000, 0);
        fetch(32'h8000_0004, 0);
        fetch(32'h8000_0008, 0);
        chk("throughput_cycles", 32'(cycle - t0), 32'd9);

        // Decode stall for five cycles, then sequential fetch continues
        fetch(32'h8000_000C, 5);

        // Redirect during WAIT: the returning word is dropped
        chk("r038_req_addr", bus.imem_req_addr, 32'h8000_0010);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("r038_out_valid_a", 32'(bus.out_valid),      32'd0);
        chk("r038_misalign",    32'(bus.misalign_err),   32'd0);
        chk("r038_no_req",      32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk("r038_out_valid_b", 32'(bus.out_valid),      32'd0);
        chk("r038_req_valid",   32'(bus.imem_req_valid), 32'd1);
        chk("r038_next_addr",   bus.imem_req_addr,       32'h8000_0100);
        fetch(32'h8000_0100, 0);

        // Misaligned redirect while the request is stalled
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("r039_misalign_hi", 32'(bus.misalign_err),   32'd1);
        chk("r039_req_valid",   32'(bus.imem_req_valid), 32'd1);
        chk("r039_held_addr_a", bus.imem_req_addr,       32'h8000_0104);
        cyc();
        chk("r039_misalign_lo", 32'(bus.misalign_err),   32'd0);
        chk("r039_held_addr_b", bus.imem_req_addr,       32'h8000_0104);
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        chk("r039_out_valid_a", 32'(bus.out_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(32'h8000_0104);
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk("r039_out_valid_b", 32'(bus.out_valid),      32'd0);
        chk("r039_req_valid_b", 32'(bus.imem_req_valid), 32'd1);
        chk("r039_next_addr",   bus.imem_req_addr,       32'h8000_0100);
        fetch(32'h8000_0100, 0);

        // Reset pulse in the middle of WAIT
        bus.imem_req_ready = 1'b1;
        cyc();
        bus.imem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        cyc();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(32'h8000_0104);
        rst_n = 1'b1;
        cyc();
        bus.imem_rsp_valid = 1'b0;
        chk("r040_out_valid",  32'(bus.out_valid),      32'd0);
        chk("r040_req_valid",  32'(bus.imem_req_valid), 32'd1);
        chk("r040_restart",    bus.imem_req_addr,       32'h8000_0000);
        fetch(32'h8000_0000, 0);

        // Randomized traffic against a fetch-stream model
        arch_pc    = 32'h8000_0004;
        pending    = 1'b0;
        pend_addr  = 32'h0;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        exp_mis    = 1'b0;
        cnt        = 0;
        delivered  = 0;
        for (int i = 0; i < 3000; i++) begin
            chk("rnd_misalign", 32'(bus.misalign_err), 32'(exp_mis));
            if (prev_stall) begin
                chk("rnd_req_stable_v", 32'(bus.imem_req_valid), 32'd1);
                chk("rnd_req_stable_a", bus.imem_req_addr,       prev_addr);
            end
            chk("rnd_one_in_flight",
                32'(bus.imem_req_valid && (pending || bus.out_valid)), 32'd0);

            if (pending && cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend_addr);
                pending = 1'b0;
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
                if (pending) cnt--;
            end
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.out_ready      = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = {20'h80000, 12'($urandom)};

            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pending   = 1'b1;
                pend_addr = bus.imem_req_addr;
                cnt       = $urandom_range(0, 2);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_out_pc",    bus.out_pc,    arch_pc);
                chk("rnd_out_instr", bus.out_instr, mem_word(arch_pc));
                arch_pc = arch_pc + 32'd4;
                delivered++;
            end
            if (bus.redirect_valid) begin
                arch_pc = {bus.redirect_pc[31:2], 2'b00};
            end
            exp_mis    = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
            cyc();
        end
        bus.redirect_valid = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        chk("rnd_progress", 32'(delivered > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts the request.
REQ-006 imem_req_addr  output  32  fetch address, word-aligned.
REQ-007 imem_rsp_valid  input  1  instruction word returned; no backpressure.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 out_valid  output  1  instruction available to decode.
REQ-010 out_ready  input  1  decode consumes the instruction.
REQ-011 out_instr  output  32  instruction word to decode.
REQ-012 out_pc  output  32  PC of out_instr.
REQ-013 redirect_valid  input  1  jump/branch redirect from execute.
REQ-014 redirect_pc  input  32  redirect target.
REQ-015 misalign_err  output  1  one-cycle pulse when redirect_pc[1:0] != 0.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD; at most one fetch in flight.
REQ-017 IDLE: outputs quiet; moves to REQ on the first clk after rst_n deasserts.
REQ-018 REQ: imem_req_valid=1, imem_req_addr=pc; imem_req_ready moves the FSM to WAIT.
REQ-019 While a request is unaccepted, imem_req_valid and imem_req_addr stay stable.
REQ-020 WAIT without drop flag, on imem_rsp_valid: capture data into out_instr and pc into out_pc, pc<=pc+4 (mod 2^32), go to HOLD.
REQ-021 HOLD: out_valid=1 with out_instr/out_pc stable; out_ready moves the FSM to REQ.
REQ-022 Minimum throughput: one instruction per 3 cycles with zero-wait memory.
REQ-023 redirect_valid in any non-IDLE state: pc<={redirect_pc[31:2],2'b00} at the next edge.
REQ-024 Redirect in REQ without imem_req_ready: hold the old request and set drop flag; after acceptance, discard the response.
REQ-025 Redirect in REQ with imem_req_ready in the same cycle: go to WAIT with drop flag set.
REQ-026 Redirect in WAIT without imem_rsp_valid: set drop flag and stay in WAIT. With imem_rsp_valid in the same cycle: discard the word and go to REQ.
REQ-027 In WAIT with drop flag set, imem_rsp_valid clears the flag, discards the word, and returns the FSM to REQ.
REQ-028 Redirect in HOLD: out_valid deasserts next cycle and the FSM goes to REQ. If out_ready is also high, the held instruction counts as consumed.
REQ-029 misalign_err pulses one cycle, the cycle after any redirect with redirect_pc[1:0] != 0.
REQ-030 out_valid is never asserted while the drop flag is set.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE, pc=RESET_PC, drop=0.
REQ-032 On rst_n low, asynchronously: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=RESET_PC, misalign_err=0.
REQ-033 Reset mid-transaction abandons the outstanding fetch; imem_rsp_valid arriving during IDLE is ignored.

Structure
REQ-034 Shared package npc_pkg holds RESET_PC, the NOP constant 32'h0000_0013, and the ifu_state_t enum.
REQ-035 Single module, no sub-module; the PC register, FSM, and output buffer are inline.

Verification
REQ-036 Reset release, zero-wait memory, out_ready=1: requests at 0x8000_0000, 0x8000_0004, 0x8000_0008, one every 3 cycles; out_pc matches each.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD: out_instr/out_pc stable and no new imem_req_valid; release, then next addr = +4.
REQ-038 Redirect to 0x8000_0100 during WAIT, response 0xDEAD_BEEF one cycle later: word dropped, out_valid stays 0, next request addr 0x8000_0100.
REQ-039 Redirect to 0x8000_0102 while imem_req_ready=0 in REQ: old addr held until accepted, response dropped, next addr 0x8000_0100, misalign_err pulses once.
REQ-040 rst_n pulsed low mid-WAIT: outputs return to reset values immediately; a late imem_rsp_valid is ignored; fetch restarts at 0x8000_0000.
